// File: rtl/snake_pkg.sv
// Shared definitions for the snake body controller: geometry, direction codes,
// FSM states and the slot-to-bus packing helper.
package snake_pkg;

    localparam int SEG_W   = 6;
    localparam int MAX_LEN = 100;
    localparam int LEN_W   = 7;
    localparam int X_MAX   = 63;
    localparam int Y_MAX   = 47;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam logic [LEN_W-1:0] LEN_MAX_C = 7'd100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_CHECK = 3'd3,
        ST_DEAD  = 3'd4
    } state_t;

    // Slot 0 (head) sits in the most significant field of the packed bus.
    function automatic int slot_off(input int k);
        return (MAX_LEN - 1 - k) * SEG_W;
    endfunction

endpackage

// File: rtl/snake_next_head.sv
// Candidate-head generator: drops exact-reverse requests and applies the
// one-cell delta in wrapping 6-bit arithmetic.
module snake_next_head
    import snake_pkg::*;
(
    input  logic [1:0]       cur_dir,
    input  logic [1:0]       dir,
    input  logic [SEG_W-1:0] head_x,
    input  logic [SEG_W-1:0] head_y,
    output logic [1:0]       new_dir,
    output logic [SEG_W-1:0] cand_x,
    output logic [SEG_W-1:0] cand_y
);

    // Direction filter and coordinate delta.
    always_comb begin
        new_dir = dir;
        cand_x  = head_x;
        cand_y  = head_y;
        if (dir == (cur_dir ^ 2'd2)) begin
            new_dir = cur_dir;
        end else begin
            new_dir = dir;
        end
        case (new_dir)
            DIR_UP:    cand_y = head_y - 6'd1;
            DIR_RIGHT: cand_x = head_x + 6'd1;
            DIR_DOWN:  cand_y = head_y + 6'd1;
            DIR_LEFT:  cand_x = head_x - 6'd1;
            default: begin
                cand_x = head_x;
                cand_y = head_y;
            end
        endcase
    end

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake segment list owner: issues the next-head query on each move tick and,
// from the one-bit collision answer, either shifts/grows the body or ends the game.
module snake_body_ctrl
    import snake_pkg::*;
#(
    parameter int INIT_LEN = 3,
    parameter int START_X  = 32,
    parameter int START_Y  = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   step_tick,
    input  logic [1:0]             dir,
    input  logic                   grow,
    input  logic                   hit,
    output logic [SEG_W-1:0]       query_x,
    output logic [SEG_W-1:0]       query_y,
    output logic [SEG_W*MAX_LEN-1:0] snake_x,
    output logic [SEG_W*MAX_LEN-1:0] snake_y,
    output logic [SEG_W-1:0]       head_x,
    output logic [SEG_W-1:0]       head_y,
    output logic [LEN_W-1:0]       length,
    output logic                   alive,
    output logic                   dead
);

    state_t             state_r, state_next_s;
    logic [SEG_W-1:0]   seg_x_r [MAX_LEN];
    logic [SEG_W-1:0]   seg_y_r [MAX_LEN];
    logic [LEN_W-1:0]   length_r;
    logic [1:0]         cur_dir_r, new_dir_r;
    logic               grow_pend_r;
    logic [SEG_W-1:0]   query_x_r, query_y_r;
    logic               alive_r, dead_r, alive_s, dead_s;
    logic               init_s, tick_s, move_s, grow_now_s;
    logic [1:0]         nh_dir_s;
    logic [SEG_W-1:0]   nh_x_s, nh_y_s;

    snake_next_head u_next_head (
        .cur_dir (cur_dir_r),
        .dir     (dir),
        .head_x  (seg_x_r[0]),
        .head_y  (seg_y_r[0]),
        .new_dir (nh_dir_s),
        .cand_x  (nh_x_s),
        .cand_y  (nh_y_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_next_s;
    end

    // Next-state logic; start overrides tick and hit everywhere it is honoured.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:  state_next_s = start ? ST_INIT : ST_IDLE;
            ST_INIT:  state_next_s = ST_RUN;
            ST_RUN:   state_next_s = start ? ST_INIT : (step_tick ? ST_CHECK : ST_RUN);
            ST_CHECK: state_next_s = start ? ST_INIT : (hit ? ST_DEAD : ST_RUN);
            ST_DEAD:  state_next_s = start ? ST_INIT : ST_DEAD;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Status decode from the upcoming state so alive/dead can be registered.
    always_comb begin
        alive_s = 1'b0;
        dead_s  = 1'b0;
        if ((state_next_s == ST_RUN) || (state_next_s == ST_CHECK)) alive_s = 1'b1;
        else                                                        alive_s = 1'b0;
        if (state_next_s == ST_DEAD) dead_s = 1'b1;
        else                         dead_s = 1'b0;
    end

    // Datapath enables.
    always_comb begin
        init_s     = (state_r == ST_INIT);
        tick_s     = (state_r == ST_RUN) && !start && step_tick;
        move_s     = (state_r == ST_CHECK) && !start && !hit;
        grow_now_s = 1'b0;
        if (move_s && grow_pend_r && (length_r < LEN_MAX_C)) grow_now_s = 1'b1;
        else                                                 grow_now_s = 1'b0;
    end

    // Segment storage: initial body, shift on move, tail vacate when not growing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                seg_x_r[k] <= 6'd0;
                seg_y_r[k] <= 6'd0;
            end
        end else if (init_s) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                if (k < INIT_LEN) begin
                    seg_x_r[k] <= SEG_W'(START_X - k);
                    seg_y_r[k] <= SEG_W'(START_Y);
                end else begin
                    seg_x_r[k] <= 6'd0;
                    seg_y_r[k] <= 6'd0;
                end
            end
        end else if (move_s) begin
            for (int k = 1; k < MAX_LEN; k++) begin
                seg_x_r[k] <= seg_x_r[k-1];
                seg_y_r[k] <= seg_y_r[k-1];
            end
            seg_x_r[0] <= query_x_r;
            seg_y_r[0] <= query_y_r;
            // At full length the old tail simply falls off the end of the list.
            for (int k = 1; k < MAX_LEN; k++) begin
                if (!grow_now_s && (LEN_W'(k) == length_r)) begin
                    seg_x_r[k] <= 6'd0;
                    seg_y_r[k] <= 6'd0;
                end
            end
        end
    end

    // Control registers: length, directions, pending growth, query, status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            length_r    <= 7'd0;
            cur_dir_r   <= DIR_RIGHT;
            new_dir_r   <= DIR_RIGHT;
            grow_pend_r <= 1'b0;
            query_x_r   <= 6'd0;
            query_y_r   <= 6'd0;
            alive_r     <= 1'b0;
            dead_r      <= 1'b0;
        end else begin
            alive_r <= alive_s;
            dead_r  <= dead_s;
            if (init_s) begin
                length_r    <= LEN_W'(INIT_LEN);
                cur_dir_r   <= DIR_RIGHT;
                grow_pend_r <= 1'b0;
            end else begin
                if (grow_now_s) length_r <= length_r + 7'd1;
                if (move_s)     cur_dir_r <= new_dir_r;
                // A pulse landing on the consuming move stays pending for the next one.
                if (move_s && grow_pend_r) grow_pend_r <= grow;
                else if (grow)             grow_pend_r <= 1'b1;
            end
            if (tick_s) begin
                new_dir_r <= nh_dir_s;
                query_x_r <= nh_x_s;
                query_y_r <= nh_y_s;
            end
        end
    end

    for (genvar k = 0; k < MAX_LEN; k++) begin : g_pack
        assign snake_x[slot_off(k) +: SEG_W] = seg_x_r[k];
        assign snake_y[slot_off(k) +: SEG_W] = seg_y_r[k];
    end

    assign query_x = query_x_r;
    assign query_y = query_y_r;
    assign head_x  = seg_x_r[0];
    assign head_y  = seg_y_r[0];
    assign length  = length_r;
    assign alive   = alive_r;
    assign dead    = dead_r;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Directed self-checking bench for snake_body_ctrl: one task per scenario with
// hand-computed expectations.
module tb_snake_body_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         step_tick = 1'b0;
    logic [1:0]   dir = 2'd1;
    logic         grow = 1'b0;
    logic         hit = 1'b0;
    logic [5:0]   query_x, query_y, head_x, head_y;
    logic [599:0] snake_x, snake_y;
    logic [6:0]   length;
    logic         alive, dead;

    int n_cmp = 0;
    int n_err = 0;

    snake_body_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step_tick(step_tick),
        .dir(dir), .grow(grow), .hit(hit),
        .query_x(query_x), .query_y(query_y),
        .snake_x(snake_x), .snake_y(snake_y),
        .head_x(head_x), .head_y(head_y),
        .length(length), .alive(alive), .dead(dead)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] sx(input int k);
        return snake_x[(99-k)*6 +: 6];
    endfunction

    function automatic logic [5:0] sy(input int k);
        return snake_y[(99-k)*6 +: 6];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
    endtask

    // Tick, then answer the query during CHECK.
    task automatic do_step(input logic [1:0] d, input logic h, input logic g);
        step_tick = 1'b1;
        dir = d;
        grow = g;
        cyc();
        step_tick = 1'b0;
        grow = 1'b0;
        hit = h;
        cyc();
        hit = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        n_cmp++; if (length !== 7'd0) begin n_err++; $display("FAIL reset_len got %0d exp 0", length); end
        n_cmp++; if ({alive, dead} !== 2'b00) begin n_err++; $display("FAIL reset_status got %b exp 00", {alive, dead}); end
        n_cmp++; if ({query_x, query_y, head_x, head_y} !== 24'd0) begin n_err++; $display("FAIL reset_qh got %h exp 0", {query_x, query_y, head_x, head_y}); end
        n_cmp++; if ({snake_x, snake_y} !== 1200'd0) begin n_err++; $display("FAIL reset_bus got nonzero exp 0"); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_start();
        do_start();
        n_cmp++; if ({head_x, head_y} !== {6'd32, 6'd24}) begin n_err++; $display("FAIL start_head got (%0d,%0d) exp (32,24)", head_x, head_y); end
        n_cmp++; if ({sx(1), sy(1), sx(2), sy(2)} !== {6'd31, 6'd24, 6'd30, 6'd24}) begin n_err++; $display("FAIL start_body got (%0d,%0d)(%0d,%0d) exp (31,24)(30,24)", sx(1), sy(1), sx(2), sy(2)); end
        n_cmp++; if ({sx(3), sy(3)} !== 12'd0) begin n_err++; $display("FAIL start_slot3 got (%0d,%0d) exp (0,0)", sx(3), sy(3)); end
        n_cmp++; if (length !== 7'd3) begin n_err++; $display("FAIL start_len got %0d exp 3", length); end
        n_cmp++; if ({alive, dead} !== 2'b10) begin n_err++; $display("FAIL start_status got %b exp 10", {alive, dead}); end
        n_cmp++; if (snake_x[599:594] !== 6'd32) begin n_err++; $display("FAIL start_pack got %0d exp 32", snake_x[599:594]); end
    endtask

    task automatic test_move();
        step_tick = 1'b1;
        dir = 2'd1;
        cyc();
        step_tick = 1'b0;
        n_cmp++; if ({query_x, query_y} !== {6'd33, 6'd24}) begin n_err++; $display("FAIL move_query got (%0d,%0d) exp (33,24)", query_x, query_y); end
        n_cmp++; if (head_x !== 6'd32) begin n_err++; $display("FAIL move_early got %0d exp 32", head_x); end
        cyc();
        n_cmp++; if ({head_x, head_y} !== {6'd33, 6'd24}) begin n_err++; $display("FAIL move_head got (%0d,%0d) exp (33,24)", head_x, head_y); end
        n_cmp++; if ({sx(2), sy(2), sx(3), sy(3)} !== {6'd31, 6'd24, 12'd0}) begin n_err++; $display("FAIL move_tail got (%0d,%0d)(%0d,%0d) exp (31,24)(0,0)", sx(2), sy(2), sx(3), sy(3)); end
        n_cmp++; if (length !== 7'd3) begin n_err++; $display("FAIL move_len got %0d exp 3", length); end
    endtask

    task automatic test_grow();
        do_start();
        grow = 1'b1;
        cyc();
        grow = 1'b0;
        do_step(2'd2, 1'b0, 1'b0);
        n_cmp++; if ({head_x, head_y} !== {6'd32, 6'd25}) begin n_err++; $display("FAIL grow_head got (%0d,%0d) exp (32,25)", head_x, head_y); end
        n_cmp++; if ({sx(3), sy(3)} !== {6'd30, 6'd24}) begin n_err++; $display("FAIL grow_slot3 got (%0d,%0d) exp (30,24)", sx(3), sy(3)); end
        n_cmp++; if (length !== 7'd4) begin n_err++; $display("FAIL grow_len got %0d exp 4", length); end
        do_step(2'd2, 1'b0, 1'b0);
        n_cmp++; if (length !== 7'd4) begin n_err++; $display("FAIL grow_keep got %0d exp 4", length); end
        n_cmp++; if ({head_y, sx(3), sx(4), sy(4)} !== {6'd26, 6'd31, 12'd0}) begin n_err++; $display("FAIL grow_shift got y%0d s3x%0d s4(%0d,%0d) exp y26 s3x31 s4(0,0)", head_y, sx(3), sx(4), sy(4)); end
    endtask

    task automatic test_reverse();
        do_start();
        do_step(2'd3, 1'b0, 1'b0);
        n_cmp++; if ({query_x, query_y} !== {6'd33, 6'd24}) begin n_err++; $display("FAIL rev_query got (%0d,%0d) exp (33,24)", query_x, query_y); end
        // Still heading right, so left remains a reverse and is ignored again.
        do_step(2'd3, 1'b0, 1'b0);
        n_cmp++; if ({head_x, head_y} !== {6'd34, 6'd24}) begin n_err++; $display("FAIL rev_dir got (%0d,%0d) exp (34,24)", head_x, head_y); end
        do_step(2'd0, 1'b0, 1'b0);
        n_cmp++; if ({head_x, head_y} !== {6'd34, 6'd23}) begin n_err++; $display("FAIL rev_up got (%0d,%0d) exp (34,23)", head_x, head_y); end
    endtask

    task automatic test_dead();
        logic [599:0] bx;
        do_start();
        bx = snake_x;
        do_step(2'd1, 1'b1, 1'b0);
        n_cmp++; if ({alive, dead} !== 2'b01) begin n_err++; $display("FAIL dead_status got %b exp 01", {alive, dead}); end
        n_cmp++; if ((snake_x !== bx) || (head_x !== 6'd32) || (length !== 7'd3)) begin n_err++; $display("FAIL dead_frozen got head %0d len %0d exp 32 3", head_x, length); end
        do_step(2'd2, 1'b0, 1'b0);
        n_cmp++; if ((snake_x !== bx) || ({query_x, query_y} !== {6'd33, 6'd24}) || (dead !== 1'b1)) begin n_err++; $display("FAIL dead_tick got q(%0d,%0d) dead %b exp q(33,24) 1", query_x, query_y, dead); end
        do_start();
        n_cmp++; if ({length, alive, dead} !== {7'd3, 2'b10}) begin n_err++; $display("FAIL dead_restart got len %0d st %b exp 3 10", length, {alive, dead}); end
    endtask

    task automatic test_restart_priority();
        do_start();
        do_step(2'd1, 1'b0, 1'b0);
        step_tick = 1'b1;
        dir = 2'd1;
        cyc();
        step_tick = 1'b0;
        start = 1'b1;
        hit = 1'b1;
        cyc();
        start = 1'b0;
        hit = 1'b0;
        cyc();
        n_cmp++; if ({dead, alive, head_x, length} !== {2'b01, 6'd32, 7'd3}) begin n_err++; $display("FAIL restart_prio got dead %b head %0d len %0d exp 0 32 3", dead, head_x, length); end
    endtask

    task automatic test_saturate();
        do_start();
        for (int i = 0; i < 97; i++) do_step(2'd1, 1'b0, 1'b1);
        n_cmp++; if (length !== 7'd100) begin n_err++; $display("FAIL sat_len100 got %0d exp 100", length); end
        n_cmp++; if ({head_x, sx(99), sy(99)} !== {6'd1, 6'd30, 6'd24}) begin n_err++; $display("FAIL sat_fill got h%0d s99(%0d,%0d) exp h1 (30,24)", head_x, sx(99), sy(99)); end
        do_step(2'd1, 1'b0, 1'b1);
        n_cmp++; if (length !== 7'd100) begin n_err++; $display("FAIL sat_len got %0d exp 100", length); end
        n_cmp++; if ({head_x, sx(99), sy(99)} !== {6'd2, 6'd31, 6'd24}) begin n_err++; $display("FAIL sat_tail got h%0d s99(%0d,%0d) exp h2 (31,24)", head_x, sx(99), sy(99)); end
    endtask

    task automatic test_async_reset();
        do_start();
        step_tick = 1'b1;
        dir = 2'd1;
        cyc();
        step_tick = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if ({length, alive, dead, query_x, query_y, head_x, head_y} !== 33'd0) begin n_err++; $display("FAIL async_rst got len %0d st %b q(%0d,%0d) exp all 0", length, {alive, dead}, query_x, query_y); end
        n_cmp++; if ({snake_x, snake_y} !== 1200'd0) begin n_err++; $display("FAIL async_bus got nonzero exp 0"); end
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_start();
        test_move();
        test_grow();
        test_reverse();
        test_dead();
        test_restart_priority();
        test_saturate();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
